// File: rtl/pipe_fetch_seq_if.sv
// Fetch-to-pipeline-register bundle for pipe_fetch_seq.
// The slave side is the sequencer. The master side is whoever drives the fetched bytes and the condition flag.
interface pipe_fetch_seq_if;
  logic [7:0] if_byte;
  logic       if_valid;
  logic       flag_ok;
  logic [7:0] op_out;
  logic [7:0] od_out;
  logic       op_valid;
  logic       pc_inc;
  logic       stall;
  logic       flush;
  logic [1:0] state;

  modport slave (
    input  if_byte, if_valid, flag_ok,
    output op_out, od_out, op_valid, pc_inc, stall, flush, state
  );

  modport master (
    output if_byte, if_valid, flag_ok,
    input  op_out, od_out, op_valid, pc_inc, stall, flush, state
  );
endinterface

// File: rtl/pipe_fetch_seq.sv
// Fetch-side sequencer for the RNBIP-2 pipeline.
// It assembles one-byte and two-byte instructions and issues each one the cycle after its last byte arrives.
// After a taken transfer it discards wrong-path bytes.
// Returns first wait out the stack-read latency, then discard wrong-path bytes.
module pipe_fetch_seq #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_LAT      = 1
) (
  input logic             clk,
  input logic             rst,
  pipe_fetch_seq_if.slave bus
);

  localparam int unsigned CNT_MAX = (FLUSH_CYCLES > MEM_LAT) ? FLUSH_CYCLES : MEM_LAT;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_OPND  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Opcodes that are followed by an operand byte.
  function automatic logic is_two_byte(input logic [7:0] op);
    logic hi_imm;
    hi_imm = op[7] & op[3] & (op[6:4] != 3'b111);
    return (op == 8'h03) || (op == 8'h05) || (op[7:3] == 5'b00001) ||
           (op[7:3] == 5'b00110) || (op[7:3] == 5'b01011) || hi_imm;
  endfunction

  // Transfers that are taken whatever the flags are.
  function automatic logic is_uncond_xfer(input logic [7:0] op);
    return (op[7:3] == 5'b00000) && (op[2:0] >= 3'd3);
  endfunction

  // Transfers that are taken only when the condition field holds.
  function automatic logic is_cond_xfer(input logic [7:0] op);
    return (op[7:3] == 5'b00001) || (op[7:3] == 5'b00101) || (op[7:3] == 5'b00110) ||
           (op[7:3] == 5'b00111) || (op[7:3] == 5'b01001);
  endfunction

  function automatic logic xfer_taken(input logic [7:0] op, input logic ok);
    return is_uncond_xfer(op) | (is_cond_xfer(op) & ok);
  endfunction

  // RTU always pops the return address. RTC pops it only when taken.
  function automatic logic ret_taken(input logic [7:0] op, input logic ok);
    return (op == 8'h07) | ((op[7:3] == 5'b01001) & ok);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic [7:0]       op_out_q, op_out_d;
  logic [7:0]       od_out_q, od_out_d;
  logic             op_valid_q, op_valid_d;
  logic             stall_q, stall_d;
  logic             flush_q, flush_d;
  logic             complete_s;
  logic [7:0]       cmpl_op_s;

  // Next-state, counter and issue logic; a completing instruction overrides the state chosen by the case.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    od_out_d   = od_out_q;
    op_out_d   = 8'h00;
    op_valid_d = 1'b0;
    complete_s = 1'b0;
    cmpl_op_s  = 8'h00;

    case (state_q)
      ST_RUN: begin
        if (bus.if_valid) begin
          if (is_two_byte(bus.if_byte)) begin
            hold_d  = bus.if_byte;
            state_d = ST_OPND;
          end else begin
            complete_s = 1'b1;
            cmpl_op_s  = bus.if_byte;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_OPND: begin
        if (bus.if_valid) begin
          od_out_d   = bus.if_byte;
          complete_s = 1'b1;
          cmpl_op_s  = hold_q;
        end else begin
          state_d = ST_OPND;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase

    if (complete_s) begin
      op_out_d   = cmpl_op_s;
      op_valid_d = 1'b1;
      if (ret_taken(cmpl_op_s, bus.flag_ok)) begin
        state_d = ST_WAIT;
        cnt_d   = WAIT_LOAD;
      end else if (xfer_taken(cmpl_op_s, bus.flag_ok)) begin
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_LOAD;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      op_valid_d = 1'b0;
    end

    stall_d = (state_d == ST_WAIT);
    flush_d = (state_d == ST_FLUSH);
  end

  // State, counter and registered outputs; reset drops any half-assembled instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= CNT_ZERO;
      hold_q     <= 8'h00;
      op_out_q   <= 8'h00;
      od_out_q   <= 8'h00;
      op_valid_q <= 1'b0;
      stall_q    <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      op_out_q   <= op_out_d;
      od_out_q   <= od_out_d;
      op_valid_q <= op_valid_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.op_out   = op_out_q;
  assign bus.od_out   = od_out_q;
  assign bus.op_valid = op_valid_q;
  assign bus.stall    = stall_q;
  assign bus.flush    = flush_q;
  assign bus.state    = state_q;
  assign bus.pc_inc   = bus.if_valid & ((state_q == ST_RUN) | (state_q == ST_OPND)) & ~rst;

endmodule

// File: tb/tb_pipe_fetch_seq.sv
// Directed, table-driven bench for pipe_fetch_seq with FLUSH_CYCLES=2 and MEM_LAT=2.
// Each table row gives the inputs driven for one cycle and the outputs expected in that same cycle.
module tb_pipe_fetch_seq;
  logic clk;
  logic rst;
  pipe_fetch_seq_if bus ();

  pipe_fetch_seq #(.FLUSH_CYCLES(2), .MEM_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] b;
    logic       f;
    logic [7:0] op;
    logic [7:0] od;
    logic       ov;
    logic       pc;
    logic       st;
    logic       fl;
    logic [1:0] s;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic r, input logic v, input logic [7:0] b, input logic f,
                              input logic [7:0] op, input logic [7:0] od, input logic ov,
                              input logic pc, input logic st, input logic fl, input logic [1:0] s);
    vec_t e;
    e.rst = r; e.v = v; e.b = b; e.f = f;
    e.op = op; e.od = od; e.ov = ov; e.pc = pc; e.st = st; e.fl = fl; e.s = s;
    vecs.push_back(e);
  endfunction

  task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let the outputs settle.
  task automatic drive(input logic r, input logic v, input logic [7:0] b, input logic f);
    @(negedge clk);
    rst = r;
    bus.if_valid = v;
    bus.if_byte = b;
    bus.flag_ok = f;
    #1;
  endtask

  initial begin
    logic found;
    rst = 1'b1;
    bus.if_valid = 1'b0;
    bus.if_byte = 8'h00;
    bus.flag_ok = 1'b0;
    repeat (2) @(posedge clk);

    //  rst v  byte  f    op     od     ov pc st fl state
    add(1, 1, 8'h55, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0); // 0  in reset: pc_inc gated
    add(0, 1, 8'h01, 0, 8'h00, 8'h00, 0, 1, 0, 0, 2'd0); // 1  back-to-back one-byte
    add(0, 1, 8'h40, 0, 8'h01, 8'h00, 1, 1, 0, 0, 2'd0);
    add(0, 1, 8'h83, 0, 8'h40, 8'h00, 1, 1, 0, 0, 2'd0);
    add(0, 1, 8'h5B, 0, 8'h83, 8'h00, 1, 1, 0, 0, 2'd0); // 4  MVI opcode
    add(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd1); // 5  operand stall
    add(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd1);
    add(0, 1, 8'h7F, 0, 8'h00, 8'h00, 0, 1, 0, 0, 2'd1); // 7  operand accepted
    add(0, 1, 8'h04, 0, 8'h5B, 8'h7F, 1, 1, 0, 0, 2'd0); // 8  JUA
    add(0, 1, 8'hAA, 0, 8'h04, 8'h7F, 1, 0, 0, 1, 2'd3); // 9  issue cycle already flushing
    add(0, 1, 8'hBB, 0, 8'h00, 8'h7F, 0, 0, 0, 1, 2'd3);
    add(0, 1, 8'h01, 0, 8'h00, 8'h7F, 0, 1, 0, 0, 2'd0); // 11 first accept after flush
    add(0, 1, 8'h09, 0, 8'h01, 8'h7F, 1, 1, 0, 0, 2'd0); // 12 JCD opcode
    add(0, 1, 8'h20, 0, 8'h00, 8'h7F, 0, 1, 0, 0, 2'd1); // 13 operand, not taken
    add(0, 1, 8'h09, 1, 8'h09, 8'h20, 1, 1, 0, 0, 2'd0); // 14 issued, no flush
    add(0, 1, 8'h21, 1, 8'h00, 8'h20, 0, 1, 0, 0, 2'd1); // 15 operand, taken
    add(0, 1, 8'hC3, 0, 8'h09, 8'h21, 1, 0, 0, 1, 2'd3);
    add(0, 1, 8'hC3, 0, 8'h00, 8'h21, 0, 0, 0, 1, 2'd3);
    add(0, 1, 8'h07, 0, 8'h00, 8'h21, 0, 1, 0, 0, 2'd0); // 18 RTU
    add(0, 1, 8'h11, 0, 8'h07, 8'h21, 1, 0, 1, 0, 2'd2); // 19 wait 1
    add(0, 1, 8'h12, 0, 8'h00, 8'h21, 0, 0, 1, 0, 2'd2); // 20 wait 2
    add(0, 1, 8'h13, 0, 8'h00, 8'h21, 0, 0, 0, 1, 2'd3); // 21 flush 1
    add(0, 1, 8'h14, 0, 8'h00, 8'h21, 0, 0, 0, 1, 2'd3); // 22 flush 2
    add(0, 1, 8'h4A, 0, 8'h00, 8'h21, 0, 1, 0, 0, 2'd0); // 23 RTC, not taken
    add(0, 1, 8'h4A, 1, 8'h4A, 8'h21, 1, 1, 0, 0, 2'd0); // 24 RTC, taken
    add(0, 1, 8'h15, 0, 8'h4A, 8'h21, 1, 0, 1, 0, 2'd2); // 25 wait 1
    add(1, 1, 8'h16, 0, 8'h00, 8'h21, 0, 0, 1, 0, 2'd2); // 26 reset in wait 2
    add(0, 1, 8'hE9, 0, 8'h00, 8'h00, 0, 1, 0, 0, 2'd0); // 27 reset values, XRI accepted
    add(0, 1, 8'hF0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 2'd1);
    add(0, 0, 8'h00, 0, 8'hE9, 8'hF0, 1, 0, 0, 0, 2'd0);
    add(0, 1, 8'h3C, 1, 8'h00, 8'hF0, 0, 1, 0, 0, 2'd0); // 30 one-byte conditional, taken
    add(0, 1, 8'h05, 0, 8'h3C, 8'hF0, 1, 0, 0, 1, 2'd3);
    add(0, 1, 8'h05, 0, 8'h00, 8'hF0, 0, 0, 0, 1, 2'd3);
    add(0, 1, 8'h05, 0, 8'h00, 8'hF0, 0, 1, 0, 0, 2'd0); // 33 CUD opcode
    add(0, 1, 8'h77, 0, 8'h00, 8'hF0, 0, 1, 0, 0, 2'd1); // 34 taken with flag_ok=0
    add(0, 1, 8'hF8, 0, 8'h05, 8'h77, 1, 0, 0, 1, 2'd3);
    add(0, 1, 8'hF8, 0, 8'h00, 8'h77, 0, 0, 0, 1, 2'd3);
    add(0, 1, 8'hF8, 0, 8'h00, 8'h77, 0, 1, 0, 0, 2'd0); // 37 1111_xxxx is one byte
    add(0, 0, 8'h00, 0, 8'hF8, 8'h77, 1, 0, 0, 0, 2'd0);
    add(0, 0, 8'h00, 0, 8'h00, 8'h77, 0, 0, 0, 0, 2'd0);
    add(0, 1, 8'h8B, 0, 8'h00, 8'h77, 0, 1, 0, 0, 2'd0); // 40 ADI opcode
    add(1, 1, 8'h99, 0, 8'h00, 8'h77, 0, 0, 0, 0, 2'd1); // 41 reset mid-OPND
    add(0, 1, 8'h01, 0, 8'h00, 8'h00, 0, 1, 0, 0, 2'd0); // 42 held opcode dropped
    add(0, 0, 8'h00, 0, 8'h01, 8'h00, 1, 0, 0, 0, 2'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].b, vecs[i].f);
      chk("op_out",   i, bus.op_out, vecs[i].op);
      chk("od_out",   i, bus.od_out, vecs[i].od);
      chk("op_valid", i, 8'(bus.op_valid), 8'(vecs[i].ov));
      chk("pc_inc",   i, 8'(bus.pc_inc),   8'(vecs[i].pc));
      chk("stall",    i, 8'(bus.stall),    8'(vecs[i].st));
      chk("flush",    i, 8'(bus.flush),    8'(vecs[i].fl));
      chk("state",    i, 8'(bus.state),    8'(vecs[i].s));
    end

    // Reset during a flush aborts it, then a two-byte instruction issues within a bounded wait.
    drive(0, 1, 8'h06, 0);
    chk("seq_a_state", 100, 8'(bus.state), 8'd0);
    drive(0, 1, 8'hAA, 0);
    chk("seq_a_flush", 101, 8'(bus.flush), 8'd1);
    chk("seq_a_op", 101, bus.op_out, 8'h06);
    drive(1, 1, 8'hBB, 0);
    chk("seq_a_pcinc_rst", 102, 8'(bus.pc_inc), 8'd0);
    drive(0, 1, 8'h8C, 0);
    chk("seq_a_rst_state", 103, 8'(bus.state), 8'd0);
    chk("seq_a_rst_flush", 103, 8'(bus.flush), 8'd0);
    chk("seq_a_accept", 103, 8'(bus.pc_inc), 8'd1);
    drive(0, 1, 8'h33, 0);
    chk("seq_a_opnd", 104, 8'(bus.state), 8'd1);
    drive(0, 0, 8'h00, 0);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      if (bus.op_valid) begin
        found = 1'b1;
      end else begin
        drive(0, 0, 8'h00, 0);
      end
    end
    chk("seq_a_issue_seen", 105, 8'(found), 8'd1);
    chk("seq_a_issue_op", 105, bus.op_out, 8'h8C);
    chk("seq_a_issue_od", 105, bus.od_out, 8'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
